// File: rtl/jtdd_gfxarb_pkg.sv
// Shared types and defaults for the graphics ROM arbiter.
// Optional round-robin grant: JTDD_GFXARB_RR_EN.
package jtdd_gfxarb_pkg;

    localparam int SDRAM_AW = 22;

    localparam logic [SDRAM_AW-1:0] DEF_CHAR_OFFSET = 22'h00000;
    localparam logic [SDRAM_AW-1:0] DEF_SCR_OFFSET  = 22'h08000;
    localparam logic [SDRAM_AW-1:0] DEF_OBJ_OFFSET  = 22'h28000;

    typedef enum logic [1:0] {
        CH_CHAR = 2'd0,
        CH_SCR  = 2'd1,
        CH_OBJ  = 2'd2
    } channel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    function automatic channel_t pick_fixed(input logic [2:0] miss);
        if (miss[0]) return CH_CHAR;
        if (miss[1]) return CH_SCR;
        return CH_OBJ;
    endfunction

    function automatic channel_t next_ch(input channel_t ch);
        case (ch)
            CH_CHAR: return CH_SCR;
            CH_SCR:  return CH_OBJ;
            default: return CH_CHAR;
        endcase
    endfunction

    // Search starts at the slot after the last grant.
    function automatic channel_t pick_rr(input logic [2:0] miss, input channel_t last);
        channel_t ch;
        channel_t sel;
        logic     found;
        ch    = last;
        sel   = CH_CHAR;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ch = next_ch(ch);
            if (!found && miss[ch]) begin
                sel   = ch;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/jtdd_gfxarb_slot.sv
// One-word client cache: tag, valid bit and data word with a live hit compare.
module jtdd_gfxarb_slot #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          load,
    input  logic [AW-1:0] load_tag,
    input  logic [15:0]   load_data,
    output logic          hit,
    output logic [15:0]   data
);

    logic [AW-1:0] tag;
    logic          valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag   <= '0;
            valid <= 1'b0;
            data  <= 16'h0000;
        end else if (load) begin
            tag   <= load_tag;
            valid <= 1'b1;
            data  <= load_data;
        end
    end

    assign hit = valid && (tag == addr);

endmodule

// File: rtl/jtdd_gfxrom_arb.sv
// Shares one SDRAM read port between the char, scroll and object ROM fetchers.
// Define JTDD_GFXARB_RR_EN for round-robin grant instead of char > scr > obj.
module jtdd_gfxrom_arb
    import jtdd_gfxarb_pkg::*;
#(
    parameter logic [21:0] CHAR_OFFSET = DEF_CHAR_OFFSET,
    parameter logic [21:0] SCR_OFFSET  = DEF_SCR_OFFSET,
    parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] char_addr,
    output logic [7:0]  char_data,
    output logic        char_ok,
    input  logic [16:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_ok,
    input  logic [18:0] obj_addr,
    output logic [15:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_din
);

    state_t      state, state_nx;
    channel_t    grant, grant_nx, pick;
    logic [18:0] tag, tag_nx, pick_wa;
    logic [21:0] pick_off, addr_nx;
    logic        req_nx, load;
    logic        char_hit, scr_hit, obj_hit;
    logic [15:0] char_word;
    logic [2:0]  miss;

    assign miss = {~obj_hit, ~scr_hit, ~char_hit};

`ifdef JTDD_GFXARB_RR_EN
    channel_t last, last_nx;
    assign pick = pick_rr(miss, last);
`else
    assign pick = pick_fixed(miss);
`endif

    always_comb begin
        pick_wa  = obj_addr;
        pick_off = OBJ_OFFSET;
        case (pick)
            CH_CHAR: begin
                pick_wa  = {4'b0000, char_addr[15:1]};
                pick_off = CHAR_OFFSET;
            end
            CH_SCR: begin
                pick_wa  = {2'b00, scr_addr};
                pick_off = SCR_OFFSET;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        tag_nx   = tag;
        addr_nx  = sdram_addr;
        req_nx   = sdram_req;
        load     = 1'b0;
`ifdef JTDD_GFXARB_RR_EN
        last_nx  = last;
`endif
        case (state)
            IDLE: begin
                if (|miss) begin
                    grant_nx = pick;
                    tag_nx   = pick_wa;
                    addr_nx  = pick_off + {3'b000, pick_wa};
                    req_nx   = 1'b1;
                    state_nx = WAIT_ACK;
`ifdef JTDD_GFXARB_RR_EN
                    last_nx  = pick;
`endif
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_nx = 1'b0;
                    // Data may arrive in the same cycle as the ack.
                    if (sdram_rdy) begin
                        load     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (sdram_rdy) begin
                    load     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= CH_CHAR;
            tag        <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
`ifdef JTDD_GFXARB_RR_EN
            last       <= CH_CHAR;
`endif
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            tag        <= tag_nx;
            sdram_addr <= addr_nx;
            sdram_req  <= req_nx;
`ifdef JTDD_GFXARB_RR_EN
            last       <= last_nx;
`endif
        end
    end

    // Fills land under the latched tag, so an address that moved mid-fetch still misses.
    jtdd_gfxarb_slot #(.AW(15)) u_char (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (char_addr[15:1]),
        .load      (load && (grant == CH_CHAR)),
        .load_tag  (tag[14:0]),
        .load_data (sdram_din),
        .hit       (char_hit),
        .data      (char_word)
    );

    jtdd_gfxarb_slot #(.AW(17)) u_scr (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (scr_addr),
        .load      (load && (grant == CH_SCR)),
        .load_tag  (tag[16:0]),
        .load_data (sdram_din),
        .hit       (scr_hit),
        .data      (scr_data)
    );

    jtdd_gfxarb_slot #(.AW(19)) u_obj (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (obj_addr),
        .load      (load && (grant == CH_OBJ)),
        .load_tag  (tag),
        .load_data (sdram_din),
        .hit       (obj_hit),
        .data      (obj_data)
    );

    assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];
    assign char_ok   = char_hit;
    assign scr_ok    = scr_hit;
    assign obj_ok    = obj_hit;

endmodule

// File: tb/tb_jtdd_gfxrom_arb.sv
// Self-checking bench for jtdd_gfxrom_arb: directed scenarios plus random traffic vs a cache model.
module tb_jtdd_gfxrom_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] char_addr;
    logic [7:0]  char_data;
    logic        char_ok;
    logic [16:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ok;
    logic [18:0] obj_addr;
    logic [15:0] obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_din;

    // second instance: object region placed at the top of SDRAM to exercise the wrap
    logic [7:0]  w_char_data;
    logic        w_char_ok, w_scr_ok, w_obj_ok, w_req;
    logic [15:0] w_scr_data, w_obj_data;
    logic [21:0] w_addr;

    always #5 clk = ~clk;

    jtdd_gfxrom_arb dut (
        .clk(clk), .rst_n(rst_n),
        .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
        .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
    );

    jtdd_gfxrom_arb #(.OBJ_OFFSET(22'h3FFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .char_addr(16'h0000), .char_data(w_char_data), .char_ok(w_char_ok),
        .scr_addr(17'h00000), .scr_data(w_scr_data), .scr_ok(w_scr_ok),
        .obj_addr(19'h00002), .obj_data(w_obj_data), .obj_ok(w_obj_ok),
        .sdram_addr(w_addr), .sdram_req(w_req), .sdram_ack(w_req),
        .sdram_rdy(w_req), .sdram_din(16'h00C3)
    );

    logic [21:0] wq[$];
    always @(negedge clk)
        if (rst_n && w_req && wq.size() < 3) wq.push_back(w_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-client cache plus the single outstanding transfer.
    bit          mval[3];
    logic [18:0] mtag[3];
    logic [15:0] mdat[3];
    int          ph;     // 0 no transfer, 1 awaiting ack, 2 awaiting data
    int          gch;
    int          last;
    logic [18:0] gtag;
    logic        m_req;
    logic [21:0] m_addr;

    function automatic logic [18:0] wa(input int ch);
        if (ch == 0) return {4'b0000, char_addr[15:1]};
        if (ch == 1) return {2'b00, scr_addr};
        return obj_addr;
    endfunction

    function automatic logic [21:0] region(input int ch);
        if (ch == 0) return 22'h00000;
        if (ch == 1) return 22'h08000;
        return 22'h28000;
    endfunction

    function automatic bit mhit(input int ch);
        return mval[ch] && (mtag[ch] == wa(ch));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mval[i] = 1'b0;
            mtag[i] = '0;
            mdat[i] = 16'h0000;
        end
        ph = 0; gch = 0; last = 0; gtag = '0; m_req = 1'b0; m_addr = '0;
    endtask

    task automatic model_fill(input logic [15:0] din);
        mval[gch] = 1'b1;
        mtag[gch] = gtag;
        mdat[gch] = din;
        ph = 0;
    endtask

    task automatic model_step(input logic ack, input logic rdy, input logic [15:0] din);
        int  ch;
        bit  found;
        found = 1'b0;
        if (ph == 0) begin
            for (int i = 0; i < 3; i++) begin
`ifdef JTDD_GFXARB_RR_EN
                ch = (last + 1 + i) % 3;
`else
                ch = i;
`endif
                if (!found && !mhit(ch)) begin
                    found = 1'b1;
                    gch   = ch;
                end
            end
            if (found) begin
                gtag   = wa(gch);
                m_addr = region(gch) + {3'b000, gtag};
                m_req  = 1'b1;
                ph     = 1;
                last   = gch;
            end
        end else if (ph == 1) begin
            if (ack) begin
                m_req = 1'b0;
                if (rdy) model_fill(din);
                else ph = 2;
            end
        end else if (rdy) begin
            model_fill(din);
        end
    endtask

    // Called at a falling edge: compare outputs, then drive inputs for the next rising edge.
    task automatic cycle(input logic [15:0] ca, input logic [16:0] sa, input logic [18:0] oa,
                         input logic ack, input logic rdy, input logic [15:0] din, input logic rst);
        logic [7:0] cb;
        cb = char_addr[0] ? mdat[0][15:8] : mdat[0][7:0];
        check("char_ok", char_ok, mhit(0));
        check("char_data", char_data, cb);
        check("scr_ok", scr_ok, mhit(1));
        check("scr_data", scr_data, mdat[1]);
        check("obj_ok", obj_ok, mhit(2));
        check("obj_data", obj_data, mdat[2]);
        check("sdram_req", sdram_req, m_req);
        check("sdram_addr", sdram_addr, m_addr);
        char_addr = ca;
        scr_addr  = sa;
        obj_addr  = oa;
        sdram_ack = ack;
        sdram_rdy = rdy;
        sdram_din = din;
        rst_n     = rst;
        if (!rst) model_clear();
        else model_step(ack, rdy, din);
    endtask

    task automatic hold(input logic ack, input logic rdy, input logic [15:0] din, input logic rst);
        cycle(char_addr, scr_addr, obj_addr, ack, rdy, din, rst);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut(input logic [15:0] ca, input logic [16:0] sa, input logic [18:0] oa);
        tick();
        cycle(ca, sa, oa, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        cycle(ca, sa, oa, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    // Serve the outstanding request, then leave one idle cycle for the next grant.
    task automatic serve(input logic [15:0] din, input bit same);
        hold(1'b1, same, din, 1'b1);
        if (!same) begin
            tick();
            hold(1'b0, 1'b1, din, 1'b1);
        end
        tick();
        hold(1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    logic [21:0] got[3];
    logic [15:0] d;
    logic [15:0] ca;
    logic [16:0] sa;
    logic [18:0] oa;
    logic        ack, rdy, rst_v;

    initial begin
        rst_n = 1'b0;
        char_addr = 16'h0003; scr_addr = 17'h4; obj_addr = 19'h2;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = 16'h0;
        model_clear();

        // first fetch, byte lanes, ack+rdy together
        reset_dut(16'h0003, 17'h00004, 19'h00002);
        tick();
        check("rst_req_released", sdram_req, 1'b1);
`ifdef JTDD_GFXARB_RR_EN
        check("first_req_addr", sdram_addr, 22'h08004);
`else
        check("first_req_addr", sdram_addr, 22'h00001);
`endif
        for (int k = 0; k < 3; k++) begin
            d = (gch == 0) ? 16'hA55A : 16'($urandom);
            serve(d, k == 1);
            tick();
        end
        check("no_dup_req", sdram_req, 1'b0);
        check("char_ok_hit", char_ok, 1'b1);
        check("char_hi_byte", char_data, 8'hA5);
        cycle(16'h0002, 17'h00004, 19'h00002, 1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        check("char_lane_ok", char_ok, 1'b1);
        check("char_lo_byte", char_data, 8'h5A);
        hold(1'b0, 1'b0, 16'h0, 1'b1);

        check("wrap_count", wq.size(), 3);
`ifdef JTDD_GFXARB_RR_EN
        check("wrap_req0", wq[0], 22'h008000);
        check("wrap_req1", wq[1], 22'h000001);
        check("wrap_req2", wq[2], 22'h000000);
`else
        check("wrap_req0", wq[0], 22'h000000);
        check("wrap_req1", wq[1], 22'h008000);
        check("wrap_req2", wq[2], 22'h000001);
`endif
        check("wrap_obj_ok", w_obj_ok, 1'b1);

        // grant order with all three missing
        reset_dut(16'h0010, 17'h00004, 19'h00002);
        for (int k = 0; k < 3; k++) begin
            tick();
            got[k] = sdram_addr;
            serve(16'(k + 1), 1'b1);
        end
`ifdef JTDD_GFXARB_RR_EN
        check("order0", got[0], 22'h08004);
        check("order1", got[1], 22'h28002);
        check("order2", got[2], 22'h00008);
`else
        check("order0", got[0], 22'h00008);
        check("order1", got[1], 22'h08004);
        check("order2", got[2], 22'h28002);
`endif

        // obj address moves while its fetch is in flight
        reset_dut(16'h0000, 17'h00000, 19'h00001);
        tick();
        for (int k = 0; k < 3 && gch != 2; k++) begin
            serve(16'h1111, 1'b1);
            tick();
        end
        check("obj_req_addr", sdram_addr, 22'h28001);
        cycle(16'h0000, 17'h00000, 19'h00002, 1'b1, 1'b0, 16'h0, 1'b1);
        tick();
        hold(1'b0, 1'b1, 16'hBEEF, 1'b1);
        tick();
        check("obj_ok_stale", obj_ok, 1'b0);
        hold(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        for (int k = 0; k < 3 && gch != 2; k++) begin
            serve(16'h2222, 1'b1);
            tick();
        end
        check("obj_req2", sdram_req, 1'b1);
        check("obj_req2_addr", sdram_addr, 22'h28002);
        serve(16'hCAFE, 1'b1);
        tick();
        check("obj_ok_new", obj_ok, 1'b1);
        check("obj_data_new", obj_data, 16'hCAFE);
        hold(1'b0, 1'b0, 16'h0, 1'b1);

        // reset while waiting for data, late rdy afterwards
        reset_dut(16'h0000, 17'h00000, 19'h00000);
        tick();
        hold(1'b1, 1'b0, 16'h0, 1'b1);
        tick();
        hold(1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        check("rst_mid_req", sdram_req, 1'b0);
        check("rst_mid_ok", {char_ok, scr_ok, obj_ok}, 3'b000);
        hold(1'b0, 1'b1, 16'hFFFF, 1'b1);
        tick();
        check("restart_req", sdram_req, 1'b1);
        check("late_rdy_ignored", {char_ok, scr_ok, obj_ok}, 3'b000);
        hold(1'b0, 1'b0, 16'h0, 1'b1);

        // random traffic
        rst_v = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            tick();
            ca = ($urandom_range(4, 0) == 0) ? 16'($urandom_range(15, 0)) : char_addr;
            sa = ($urandom_range(4, 0) == 0) ? 17'($urandom_range(7, 0)) : scr_addr;
            oa = ($urandom_range(4, 0) == 0) ? 19'($urandom_range(7, 0)) : obj_addr;
            ack = 1'b0;
            rdy = 1'b0;
            if (ph == 1) begin
                ack = ($urandom_range(1, 0) == 0);
                rdy = ack && ($urandom_range(3, 0) == 0);
            end else if (ph == 2) begin
                rdy = ($urandom_range(1, 0) == 0);
            end else begin
                rdy = ($urandom_range(9, 0) == 0);
            end
            rst_v = (rst_v == 1'b0) ? 1'b1 : ($urandom_range(99, 0) != 0);
            cycle(ca, sa, oa, ack, rdy, 16'($urandom), rst_v);
        end
        tick();
        hold(1'b0, 1'b0, 16'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtdd_gfxrom_arb.md
Name: jtdd_gfxrom_arb

Overview:
- Sits directly upstream of the video block.
- Serves the char, scroll and object ROM fetch ports (addr out, data/ok in) from one shared 16-bit SDRAM read port.
- Each client holds a one-word cache; the arbiter fetches on a cache miss and raises the client's ok once the data is valid for its current address.
- Fixed-priority by default: char > scr > obj.

Parameters:
- CHAR_OFFSET, 22'h00000: SDRAM word base of the char region.
- SCR_OFFSET, 22'h08000: SDRAM word base of the scroll region.
- OBJ_OFFSET, 22'h28000: SDRAM word base of the object region.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- char_addr  in  16  byte address from the char layer.
- char_data  out  8  char ROM byte.
- char_ok  out  1  char_data valid for the current char_addr.
- scr_addr  in  17  word address from the scroll layer.
- scr_data  out  16  scroll ROM word.
- scr_ok  out  1  scr_data valid for the current scr_addr.
- obj_addr  in  19  word address from the object layer.
- obj_data  out  16  object ROM word.
- obj_ok  out  1  obj_data valid for the current obj_addr.
- sdram_addr  out  22  word address to the SDRAM controller.
- sdram_req  out  1  read request; held high until ack.
- sdram_ack  in  1  one-cycle pulse: request accepted.
- sdram_rdy  in  1  one-cycle pulse: sdram_din valid.
- sdram_din  in  16  read data.

Behaviour:
- Reset (rst_n low, async):
  - sdram_req=0, sdram_addr=0.
  - All cache valid bits=0, all *_data=0, all *_ok=0.
  - FSM returns to IDLE; any in-flight transfer is abandoned.
- Per-client slot:
  - Holds tag (word address), valid bit and data word.
  - Char word address is char_addr[15:1].
  - hit = valid & (tag == current word address); evaluated combinationally against the live input.
  - *_ok = hit.
  - miss = ~hit.
  - char_data = char_addr[0] ? word[15:8] : word[7:0]. A byte-lane change within the same word is a hit with zero latency.
- FSM, states IDLE, WAIT_ACK, WAIT_DATA:
  - IDLE: if any slot misses, grant the highest-priority missing slot, then on that edge:
    - latch its address;
    - sdram_addr = offset + zero-extended word address (22-bit add, carry out discarded);
    - sdram_req=1;
    - go to WAIT_ACK.
  - WAIT_ACK: on sdram_ack, sdram_req=0 and go to WAIT_DATA. sdram_req never drops without ack.
  - WAIT_DATA: on sdram_rdy, write sdram_din and the latched tag into the granted slot, set valid, go to IDLE.
- Latency:
  - miss seen in cycle n gives req high at n+1.
  - ack and rdy in the same cycle as their arrival are honoured: if both pulse in one WAIT_ACK cycle, treat as ack+rdy and go straight to IDLE with data written.
  - ok rises the cycle after the rdy edge.
- Address change mid-fetch: data is still stored under the latched tag. ok stays low because of the tag mismatch, and a new request follows from IDLE. No cancel is issued to the SDRAM.
- Starvation: with fixed priority a continuously missing char client can starve obj. This is accepted; video timing guarantees idle gaps.
- sdram_addr holds its last value when idle.

Optional Feature:
- JTDD_GFXARB_RR_EN
- Defined: grant is round-robin. A last-granted pointer (reset value = char) rotates the priority so that the slot after the last grant checks first.
- Undefined: fixed char > scr > obj. The pointer logic is not synthesized.

Decomposition:
- Package jtdd_gfxarb_pkg:
  - channel enum CH_CHAR=0, CH_SCR=1, CH_OBJ=2;
  - state enum IDLE/WAIT_ACK/WAIT_DATA;
  - SDRAM_AW=22 and default offsets.
- Sub-module jtdd_gfxarb_slot (parameter AW):
  - contains the tag, valid, data, hit compare and load port;
  - instantiated three times.

Test Plan:
- Reset then char_addr=16'h0003 → req at next edge, sdram_addr=22'h00001. After rdy with din=16'hA55A → char_ok=1, char_data=8'hA5. Change to 16'h0002 → char_data=8'h5A, ok stays 1.
- All three miss at once (char 16'h0010, scr 17'h00004, obj 19'h00002) → grant order char (22'h00008), scr (22'h08004), obj (22'h28002). With RR_EN and last grant=char, order is scr, obj, char.
- obj_addr changes 19'h1 → 19'h2 while waiting on 19'h1 → stored tag 19'h1, obj_ok stays 0, second request to 22'h28002, then ok=1.
- rst_n low while in WAIT_DATA → req=0, all ok=0. A late rdy after release is ignored; a fresh miss restarts from IDLE.
- ack and rdy in the same cycle → single transfer, data written, FSM in IDLE next cycle, no duplicate request.
- OBJ_OFFSET=22'h3FFFFF, obj_addr=19'h2 → sdram_addr=22'h000001 (wrap-around).
